// File: rtl/combo_pkg.sv
// Shared state encoding, event codes and special-move IDs for the combo sequencer.
package combo_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_D,
        S_DF,
        S_DB,
        S_F,
        S_FIRE,
        S_COOLDOWN
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_PUNCH,
        EV_KICK,
        EV_DOWN,
        EV_UP,
        EV_FWD,
        EV_BACK
    } event_t;

    localparam logic [1:0] ID_NONE       = 2'd0;
    localparam logic [1:0] ID_HADOKEN    = 2'd1;
    localparam logic [1:0] ID_TATSU      = 2'd2;
    localparam logic [1:0] ID_DASH_PUNCH = 2'd3;

    function automatic logic is_partial(state_t s);
        return s inside {S_D, S_DF, S_DB, S_F};
    endfunction

    // F carries its second step in a separate flag rather than its own state.
    function automatic logic [1:0] step_of(state_t s, logic second);
        case (s)
            S_D:        return 2'd1;
            S_DF, S_DB: return 2'd2;
            S_F:        return second ? 2'd2 : 2'd1;
            default:    return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/btn_event_encoder.sv
// Rising-edge detection, facing-relative forward/back mapping and priority
// reduction of the six button levels into at most one event per cycle.
module btn_event_encoder
    import combo_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   btn_up,
    input  logic   btn_down,
    input  logic   btn_left,
    input  logic   btn_right,
    input  logic   btn_punch,
    input  logic   btn_kick,
    input  logic   facing_right,
    output logic   event_valid,
    output event_t event_code
);

    logic [5:0] lvl;
    logic [5:0] prev;
    logic [5:0] rise;
    logic       armed;
    logic       fwd_rise;
    logic       back_rise;

    assign lvl = {btn_kick, btn_punch, btn_right, btn_left, btn_down, btn_up};

    // The first clock after reset only captures levels, so a held button stays silent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev  <= '0;
            armed <= 1'b0;
        end else begin
            prev  <= lvl;
            armed <= 1'b1;
        end
    end

    assign rise      = armed ? (lvl & ~prev) : 6'b0;
    assign fwd_rise  = facing_right ? rise[3] : rise[2];
    assign back_rise = facing_right ? rise[2] : rise[3];

    always_comb begin
        event_code = EV_NONE;
        if (rise[4])        event_code = EV_PUNCH;
        else if (rise[5])   event_code = EV_KICK;
        else if (rise[1])   event_code = EV_DOWN;
        else if (rise[0])   event_code = EV_UP;
        else if (fwd_rise)  event_code = EV_FWD;
        else if (back_rise) event_code = EV_BACK;
    end

    assign event_valid = (event_code != EV_NONE);

endmodule

// File: rtl/combo_sequencer.sv
// Fighting-game style special-move detector: tracks partial button combos
// within a step window and fires a one-cycle special pulse on completion.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | no partial combo open
// S_D        | down accepted
// S_DF       | down, forward accepted
// S_DB       | down, back accepted
// S_F        | forward accepted (second=1: forward, forward)
// S_FIRE     | one-cycle special pulse
// S_COOLDOWN | all events ignored until the cooldown count elapses
module combo_sequencer
    import combo_pkg::*;
#(
    parameter int WINDOW_TICKS   = 25000000,
    parameter int COOLDOWN_TICKS = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_punch,
    input  logic       btn_kick,
    input  logic       facing_right,
    output logic       special_fire,
    output logic [1:0] special_id,
    output logic       combo_active,
    output logic [1:0] step
);

    localparam int CNT_MAX = (WINDOW_TICKS > COOLDOWN_TICKS) ? WINDOW_TICKS : COOLDOWN_TICKS;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW_TICKS - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_TICKS - 1);

    logic             ev_valid;
    event_t           ev_code;
    state_t           state;
    state_t           nxt_state;
    state_t           restart_state;
    logic             second;
    logic             nxt_second;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic [1:0]       nxt_id;

    btn_event_encoder u_enc (
        .clk          (clk),
        .reset        (reset),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_punch    (btn_punch),
        .btn_kick     (btn_kick),
        .facing_right (facing_right),
        .event_valid  (ev_valid),
        .event_code   (ev_code)
    );

    // Where any event lands when it does not extend the current combo.
    assign restart_state = (ev_code == EV_DOWN) ? S_D :
                           (ev_code == EV_FWD)  ? S_F : S_IDLE;

    always_comb begin
        nxt_state  = state;
        nxt_second = second;
        nxt_cnt    = cnt;
        nxt_id     = ID_NONE;
        case (state)
            S_IDLE: begin
                nxt_cnt = '0;
                if (ev_valid) begin
                    nxt_state  = restart_state;
                    nxt_second = 1'b0;
                end
            end
            S_D, S_DF, S_DB, S_F: begin
                // An event on the expiry cycle still counts; expiry only applies to a quiet cycle.
                if (ev_valid) begin
                    nxt_cnt    = '0;
                    nxt_state  = restart_state;
                    nxt_second = 1'b0;
                    case (state)
                        S_D: begin
                            if (ev_code == EV_FWD)       nxt_state = S_DF;
                            else if (ev_code == EV_BACK) nxt_state = S_DB;
                        end
                        S_DF: begin
                            if (ev_code == EV_PUNCH) begin
                                nxt_state = S_FIRE;
                                nxt_id    = ID_HADOKEN;
                            end
                        end
                        S_DB: begin
                            if (ev_code == EV_KICK) begin
                                nxt_state = S_FIRE;
                                nxt_id    = ID_TATSU;
                            end
                        end
                        S_F: begin
                            if (!second && ev_code == EV_FWD) begin
                                nxt_state  = S_F;
                                nxt_second = 1'b1;
                            end else if (second && ev_code == EV_PUNCH) begin
                                nxt_state = S_FIRE;
                                nxt_id    = ID_DASH_PUNCH;
                            end
                        end
                        default: ;
                    endcase
                end else if (cnt == WIN_LAST) begin
                    nxt_state  = S_IDLE;
                    nxt_cnt    = '0;
                    nxt_second = 1'b0;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            S_FIRE: begin
                nxt_state  = S_COOLDOWN;
                nxt_cnt    = '0;
                nxt_second = 1'b0;
            end
            S_COOLDOWN: begin
                if (cnt == COOL_LAST) begin
                    nxt_state = S_IDLE;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            default: begin
                nxt_state  = S_IDLE;
                nxt_cnt    = '0;
                nxt_second = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            second       <= 1'b0;
            cnt          <= '0;
            special_fire <= 1'b0;
            special_id   <= ID_NONE;
            combo_active <= 1'b0;
            step         <= 2'd0;
        end else begin
            state        <= nxt_state;
            second       <= nxt_second;
            cnt          <= nxt_cnt;
            special_fire <= (nxt_state == S_FIRE);
            special_id   <= (nxt_state == S_FIRE) ? nxt_id : ID_NONE;
            combo_active <= is_partial(nxt_state);
            step         <= step_of(nxt_state, nxt_second);
        end
    end

endmodule

// File: doc/combo_sequencer.md
COMBO_SEQUENCER -- requirements
Module: combo_sequencer

Interface
REQ-001 SHALL have parameter WINDOW_TICKS, default 25000000, max clk cycles allowed between consecutive combo steps.
REQ-002 SHALL have parameter COOLDOWN_TICKS, default 12500000, clk cycles inputs are ignored after a special fires.
REQ-003 SHALL have port clk  input  1  system clock; all state on posedge clk.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports btn_up, btn_down, btn_left, btn_right, btn_punch, btn_kick  input  1 each  synchronized, debounced button levels.
REQ-006 SHALL have port facing_right  input  1  1 = forward is right, 0 = forward is left.
REQ-007 SHALL have port special_fire  output  1  one-cycle pulse when a combo completes.
REQ-008 SHALL have port special_id  output  2  0 none, 1 HADOKEN, 2 TATSU, 3 DASH_PUNCH; valid only with special_fire, else 0.
REQ-009 SHALL have port combo_active  output  1  high while a partial combo is held open.
REQ-010 SHALL have port step  output  2  count of accepted steps of the current partial combo (0..2).

Function
REQ-011 SHALL detect rising edges of each button (registered previous level); levels held high generate no further events.
REQ-012 SHALL reduce same-cycle edges to one event, priority punch > kick > down > up > forward > back; lower-priority edges that cycle are discarded.
REQ-013 SHALL map forward/back from left/right using facing_right sampled in the same cycle as the edge.
REQ-014 SHALL recognise sequences: down,forward,punch -> id 1; down,back,kick -> id 2; forward,forward,punch -> id 3.
REQ-015 SHALL implement states IDLE, D (down), DF (down,forward), DB (down,back), F (forward), FIRE, COOLDOWN.
REQ-016 SHALL transition from IDLE: down -> D, forward -> F, other events stay IDLE.
REQ-017 SHALL transition: D+forward -> DF, D+back -> DB, F+forward -> DF? no: F+forward -> FF step handled as state F with step=2 via internal flag, F+down -> D.
REQ-018 SHALL, on completing event (DF+punch, DB+kick, F(step 2)+punch), enter FIRE for exactly one cycle with special_fire=1 and special_id set, the cycle after the completing edge.
REQ-019 SHALL, on a wrong event in any partial state, restart: down -> D (step 1), forward -> F (step 1), anything else -> IDLE.
REQ-020 SHALL reset the window counter to 0 on every accepted step and increment it each cycle in D, DF, DB, F.
REQ-021 SHALL return to IDLE when the counter reaches WINDOW_TICKS-1 with no event that cycle; an event arriving on that same cycle SHALL be processed and win over expiry.
REQ-022 SHALL go FIRE -> COOLDOWN, ignore all events for COOLDOWN_TICKS cycles, then IDLE; edges during cooldown are dropped, not queued.
REQ-023 SHALL drive combo_active=1 only in D, DF, DB, F; step = 1 in D/F(first), 2 in DF/DB/F(second), 0 otherwise.
REQ-024 SHALL size counters with $clog2 of the larger parameter; no wrap-around occurs because expiry precedes overflow.

Reset
REQ-025 SHALL, while reset=1 at any time, force state IDLE, counters 0, edge registers 0, special_fire=0, special_id=0, combo_active=0, step=0.
REQ-026 SHALL, on reset deassertion with a button already held, generate no edge for that button until it is released and pressed again (edge registers load current levels on the first clk after reset).

Structure
REQ-027 SHALL place state encoding, event codes, and combo ID constants in shared package combo_pkg.
REQ-028 SHALL implement edge detection, facing mapping and priority reduction in sub-module btn_event_encoder, outputs event_valid and event_code.

Verification (WINDOW_TICKS=8, COOLDOWN_TICKS=4, facing_right=1)
REQ-029 SHALL test down, right, punch edges 3 cycles apart -> special_fire one cycle with special_id=1, then 4 cooldown cycles, combo_active=0.
REQ-030 SHALL test facing_right=0: down, right, kick -> special_id=2; right, right, punch -> special_id=3 not fired (left required), with left, left, punch -> special_id=3.
REQ-031 SHALL test down then no input for 8 cycles -> return to IDLE, step 0; down then right on counter=7 -> accepted, step=2.
REQ-032 SHALL test down, up -> IDLE; down, kick, down -> state D, step=1; punch+down same cycle -> only punch processed.
REQ-033 SHALL test punch pressed during cooldown then released -> no fire, state IDLE afterwards.
REQ-034 SHALL test reset asserted mid DF with btn_down held -> outputs 0 immediately; after release of reset, held down yields no event.
